// File: rtl/fp_bin_inv_div.sv
// Modular inverse / divide over an odd prime field P using the binary
// extended Euclidean algorithm, one reduction step per clock.
//
// state | meaning
// IDLE  | accepting a request (o_rdy high)
// ITER  | one Euclid step per cycle until u==1, v==1 or watchdog expiry
// DONE  | result presented, held until the consumer takes it
module fp_bin_inv_div #(
    parameter int              BITS     = 381,
    parameter logic [BITS-1:0] P        = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab,
    parameter int              CTL_BITS = 8,
    parameter int              MAX_ITER = 4 * BITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_val,
    output logic                o_rdy,
    input  logic                i_mode,
    input  logic [BITS-1:0]     i_a,
    input  logic [BITS-1:0]     i_b,
    input  logic [CTL_BITS-1:0] i_ctl,
    output logic                o_val,
    input  logic                i_rdy,
    output logic [BITS-1:0]     o_dat,
    output logic                o_err,
    output logic [CTL_BITS-1:0] o_ctl
);

    localparam int CW = $clog2(MAX_ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [BITS-1:0] ONE      = BITS'(1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(MAX_ITER);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [1:0]          state_q, state_d;
    logic [BITS-1:0]     u_q, u_d, v_q, v_d;
    logic [BITS-1:0]     x1_q, x1_d, x2_q, x2_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BITS-1:0]     dat_q, dat_d;
    logic                err_q, err_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic                bad_req;

    // x/2 mod P: an odd x gets P added first so the sum is even; the
    // extra top bit keeps the carry of x+P.
    function automatic logic [BITS-1:0] halve(input logic [BITS-1:0] x);
        logic [BITS:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return s[BITS:1];
    endfunction

    // (x - y) mod P for x, y < P; the wrap of x-y is undone by adding P.
    function automatic logic [BITS-1:0] msub(input logic [BITS-1:0] x, input logic [BITS-1:0] y);
        return (x >= y) ? (x - y) : (x - y + P);
    endfunction

    assign bad_req = (i_a == '0) || (i_a >= P) || (i_mode && (i_b >= P));

    assign o_rdy = (state_q == S_IDLE);
    assign o_val = (state_q == S_DONE);
    assign o_dat = dat_q;
    assign o_err = err_q;
    assign o_ctl = ctl_q;

    // Next-state: request capture, one Euclid step, and result hand-off.
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        err_d   = err_q;
        ctl_d   = ctl_q;
        case (state_q)
            S_IDLE: begin
                if (i_val) begin
                    u_d   = i_a;
                    v_d   = P;
                    x1_d  = i_mode ? i_b : ONE;
                    x2_d  = '0;
                    ctl_d = i_ctl;
                    cnt_d = '0;
                    if (bad_req) begin
                        err_d   = 1'b1;
                        dat_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (u_q == ONE) begin
                    dat_d   = x1_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (v_q == ONE) begin
                    dat_d   = x2_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    dat_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!u_q[0]) begin
                        u_d  = u_q >> 1;
                        x1_d = halve(x1_q);
                    end else if (!v_q[0]) begin
                        v_d  = v_q >> 1;
                        x2_d = halve(x2_q);
                    end else if (u_q >= v_q) begin
                        u_d  = u_q - v_q;
                        x1_d = msub(x1_q, x2_q);
                    end else begin
                        v_d  = v_q - u_q;
                        x2_d = msub(x2_q, x1_q);
                    end
                end
            end
            S_DONE: begin
                if (i_rdy) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
            ctl_q   <= ctl_d;
        end
    end

endmodule

// File: tb/tb_fp_bin_inv_div.sv
// Bench for fp_bin_inv_div: four instances (P=13, P=13 with a tiny
// watchdog, P=2^31-1, default BLS12-381 field) checked against plain
// modular arithmetic references.
module tb_fp_bin_inv_div;

    localparam logic [383:0] P_BLS = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    localparam logic [383:0] GX    = 384'h17f1d3a73197d7942695638c4fa9ac0fc3688c4f9774b905a14e3a3f171bac586c55e83ff97a1aeffb3af00adb22c6bb;
    localparam int           MAX_BLS = 4 * 381;
    localparam longint       P_MID   = 64'd2147483647;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic [383:0] a_in = '0;
    logic [383:0] b_in = '0;
    logic [7:0]   ctl_in = '0;
    logic [3:0]   val = '0;
    logic [3:0]   rdyi = '0;
    logic [3:0]   o_rdy_v, o_val_v, o_err_v;
    logic [7:0]   octl0, octl1, octl2, octl3;
    logic [3:0]   dat0, dat1;
    logic [31:0]  dat2;
    logic [380:0] dat3;
    logic [383:0] dat_v [4];
    logic [7:0]   octl_v [4];

    int tests = 0;
    int fails = 0;

    assign dat_v[0] = {380'b0, dat0};
    assign dat_v[1] = {380'b0, dat1};
    assign dat_v[2] = {352'b0, dat2};
    assign dat_v[3] = {3'b0, dat3};
    assign octl_v[0] = octl0;
    assign octl_v[1] = octl1;
    assign octl_v[2] = octl2;
    assign octl_v[3] = octl3;

    always #5 clk = ~clk;

    fp_bin_inv_div #(.BITS(4), .P(4'd13), .CTL_BITS(8)) u_small (
        .i_clk(clk), .i_rst(rst), .i_val(val[0]), .o_rdy(o_rdy_v[0]), .i_mode(mode),
        .i_a(a_in[3:0]), .i_b(b_in[3:0]), .i_ctl(ctl_in), .o_val(o_val_v[0]),
        .i_rdy(rdyi[0]), .o_dat(dat0), .o_err(o_err_v[0]), .o_ctl(octl0));

    fp_bin_inv_div #(.BITS(4), .P(4'd13), .CTL_BITS(8), .MAX_ITER(2)) u_wdog (
        .i_clk(clk), .i_rst(rst), .i_val(val[1]), .o_rdy(o_rdy_v[1]), .i_mode(mode),
        .i_a(a_in[3:0]), .i_b(b_in[3:0]), .i_ctl(ctl_in), .o_val(o_val_v[1]),
        .i_rdy(rdyi[1]), .o_dat(dat1), .o_err(o_err_v[1]), .o_ctl(octl1));

    fp_bin_inv_div #(.BITS(32), .P(32'd2147483647), .CTL_BITS(8)) u_mid (
        .i_clk(clk), .i_rst(rst), .i_val(val[2]), .o_rdy(o_rdy_v[2]), .i_mode(mode),
        .i_a(a_in[31:0]), .i_b(b_in[31:0]), .i_ctl(ctl_in), .o_val(o_val_v[2]),
        .i_rdy(rdyi[2]), .o_dat(dat2), .o_err(o_err_v[2]), .o_ctl(octl2));

    fp_bin_inv_div u_bls (
        .i_clk(clk), .i_rst(rst), .i_val(val[3]), .o_rdy(o_rdy_v[3]), .i_mode(mode),
        .i_a(a_in[380:0]), .i_b(b_in[380:0]), .i_ctl(ctl_in), .o_val(o_val_v[3]),
        .i_rdy(rdyi[3]), .o_dat(dat3), .o_err(o_err_v[3]), .o_ctl(octl3));

    // ---------------- reference model ----------------
    function automatic longint powmod(input longint base, input longint e, input longint p);
        longint r;
        longint bb;
        longint ee;
        r = 1; bb = base % p; ee = e;
        while (ee > 0) begin
            if ((ee & 1) != 0) r = (r * bb) % p;
            bb = (bb * bb) % p;
            ee = ee >> 1;
        end
        return r;
    endfunction

    // Number of non-terminal steps until u or v reaches 1 (ordered rules).
    function automatic int ref_steps(input longint a, input longint p);
        longint u;
        longint v;
        int n;
        u = a; v = p; n = 0;
        while (u != 1 && v != 1 && n < 100000) begin
            if (u % 2 == 0)      u = u / 2;
            else if (v % 2 == 0) v = v / 2;
            else if (u >= v)     u = u - v;
            else                 v = v - u;
            n++;
        end
        return n;
    endfunction

    function automatic logic [383:0] mulmod_big(input logic [383:0] x, input logic [383:0] y);
        logic [383:0] r;
        r = '0;
        for (int i = 380; i >= 0; i--) begin
            r = r << 1;
            if (r >= P_BLS) r = r - P_BLS;
            if (x[i]) begin
                r = r + y;
                if (r >= P_BLS) r = r - P_BLS;
            end
        end
        return r;
    endfunction

    function automatic logic [383:0] rand_bls();
        logic [383:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        r[383:381] = 3'b0;
        if (r >= P_BLS) r = r - P_BLS;
        return r;
    endfunction

    // One request/response on DUT w; returns result and acceptance-to-o_val latency.
    // Entered and left on a falling edge so calls chain back-to-back.
    task automatic op(input int w, input logic md, input logic [383:0] a, input logic [383:0] b,
                      input logic [7:0] c, input int hold,
                      output logic [383:0] d, output logic e, output logic [7:0] oc, output int lat);
        tests++;
        if (o_rdy_v[w] !== 1'b1) begin
            fails++;
            $display("FAIL rdy_idle dut%0d: o_rdy=%b want 1", w, o_rdy_v[w]);
        end
        mode = md; a_in = a; b_in = b; ctl_in = c; val[w] = 1'b1;
        @(negedge clk);
        val[w] = 1'b0;
        lat = 1;
        while (o_val_v[w] !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (o_val_v[w] !== 1'b1) begin
            fails++;
            $display("FAIL timeout dut%0d: o_val=%b after %0d cycles, want 1", w, o_val_v[w], lat);
        end
        d = dat_v[w]; e = o_err_v[w]; oc = octl_v[w];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            tests++;
            if (o_val_v[w] !== 1'b1 || o_rdy_v[w] !== 1'b0 || dat_v[w] !== d ||
                octl_v[w] !== oc || o_err_v[w] !== e) begin
                fails++;
                $display("FAIL hold dut%0d cycle %0d: val=%b rdy=%b dat=%0h ctl=%h, want val=1 rdy=0 dat=%0h ctl=%h",
                         w, i, o_val_v[w], o_rdy_v[w], dat_v[w], octl_v[w], d, oc);
            end
        end
        rdyi[w] = 1'b1;
        @(negedge clk);
        rdyi[w] = 1'b0;
        tests++;
        if (o_val_v[w] !== 1'b0 || o_rdy_v[w] !== 1'b1 || o_err_v[w] !== 1'b0) begin
            fails++;
            $display("FAIL release dut%0d: val=%b rdy=%b err=%b, want 0 1 0", w, o_val_v[w], o_rdy_v[w], o_err_v[w]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            tests++;
            if (o_rdy_v[w] !== 1'b1 || o_val_v[w] !== 1'b0 || o_err_v[w] !== 1'b0 ||
                dat_v[w] !== '0 || octl_v[w] !== 8'h00) begin
                fails++;
                $display("FAIL reset dut%0d: rdy=%b val=%b err=%b dat=%0h ctl=%h, want 1 0 0 0 00",
                         w, o_rdy_v[w], o_val_v[w], o_err_v[w], dat_v[w], octl_v[w]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [383:0] d; logic e; logic [7:0] oc; int lat;
        op(0, 1'b0, 384'd3, 384'd0, 8'h5A, 0, d, e, oc, lat);
        tests++;
        if (d !== 384'd9 || e !== 1'b0 || oc !== 8'h5A || lat != ref_steps(3, 13) + 2) begin
            fails++;
            $display("FAIL inv3: dat=%0d err=%b ctl=%h lat=%0d, want 9 0 5a %0d", d, e, oc, lat, ref_steps(3, 13) + 2);
        end
        op(0, 1'b1, 384'd3, 384'd5, 8'h01, 0, d, e, oc, lat);
        tests++;
        if (d !== 384'd6 || e !== 1'b0 || oc !== 8'h01) begin
            fails++;
            $display("FAIL div5_3: dat=%0d err=%b ctl=%h, want 6 0 01", d, e, oc);
        end
        op(0, 1'b1, 384'd1, 384'd7, 8'h02, 0, d, e, oc, lat);
        tests++;
        if (d !== 384'd7 || e !== 1'b0 || lat != 2) begin
            fails++;
            $display("FAIL div7_1: dat=%0d err=%b lat=%0d, want 7 0 2", d, e, lat);
        end
    endtask

    task automatic test_errors();
        logic [383:0] d; logic e; logic [7:0] oc; int lat;
        logic [383:0] ea [4];
        logic         em [4];
        logic [383:0] eb [4];
        int           ew [4];
        ea[0] = 384'd0;  eb[0] = 384'd0;  em[0] = 1'b0; ew[0] = 0;
        ea[1] = 384'd13; eb[1] = 384'd0;  em[1] = 1'b0; ew[1] = 0;
        ea[2] = 384'd3;  eb[2] = 384'd13; em[2] = 1'b1; ew[2] = 0;
        ea[3] = 384'(P_MID); eb[3] = 384'd4; em[3] = 1'b1; ew[3] = 2;
        for (int k = 0; k < 4; k++) begin
            op(ew[k], em[k], ea[k], eb[k], 8'(8'hE0 + k), 0, d, e, oc, lat);
            tests++;
            if (e !== 1'b1 || d !== '0 || lat != 1 || oc !== 8'(8'hE0 + k)) begin
                fails++;
                $display("FAIL err_case%0d: err=%b dat=%0d lat=%0d ctl=%h, want 1 0 1 %h", k, e, d, lat, oc, 8'(8'hE0 + k));
            end
        end
        op(3, 1'b0, P_BLS, 384'd0, 8'hEE, 0, d, e, oc, lat);
        tests++;
        if (e !== 1'b1 || d !== '0 || lat != 1) begin
            fails++;
            $display("FAIL err_bls: err=%b dat=%0h lat=%0d, want 1 0 1", e, d, lat);
        end
        op(0, 1'b0, 384'd3, 384'd15, 8'h0F, 0, d, e, oc, lat);
        tests++;
        if (e !== 1'b0 || d !== 384'd9) begin
            fails++;
            $display("FAIL b_ignored: err=%b dat=%0d, want 0 9", e, d);
        end
    endtask

    // Exhaustive (nrand==0) or random sweep over a small field on DUT w.
    task automatic test_field(input int w, input longint p, input int mx, input int nrand);
        logic [383:0] d; logic e; logic [7:0] oc; int lat;
        longint a, b, bx, ex;
        int n, total, exp_lat;
        logic m, exp_err;
        logic [7:0] c;
        logic [383:0] exp_dat;
        total = (nrand == 0) ? int'((p - 1) * p) : nrand;
        for (int k = 0; k < total; k++) begin
            if (nrand == 0) begin
                a = k / p + 1;
                b = k % p;
            end else begin
                a = longint'($urandom_range(32'(p - 1), 1));
                b = longint'($urandom) % p;
            end
            m  = (b != 1);
            bx = m ? b : longint'($urandom & 32'hF);
            ex = (powmod(a, p - 2, p) * (m ? b : 1)) % p;
            c  = 8'($urandom);
            n  = ref_steps(a, p);
            exp_err = (n > mx);
            exp_lat = (exp_err ? mx : n) + 2;
            exp_dat = exp_err ? 384'd0 : 384'(ex);
            op(w, m, 384'(a), 384'(bx), c, 0, d, e, oc, lat);
            tests++;
            if (e !== exp_err || d !== exp_dat || oc !== c || lat != exp_lat) begin
                fails++;
                $display("FAIL field dut%0d a=%0d b=%0d mode=%b: dat=%0d err=%b ctl=%h lat=%0d, want dat=%0d err=%b ctl=%h lat=%0d",
                         w, a, bx, m, d, e, oc, lat, exp_dat, exp_err, c, exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [383:0] d; logic e; logic [7:0] oc; int lat;
        op(0, 1'b0, 384'd5, 384'd0, 8'hA5, 20, d, e, oc, lat);
        tests++;
        if (d !== 384'd8 || e !== 1'b0 || oc !== 8'hA5) begin
            fails++;
            $display("FAIL held_inv5: dat=%0d err=%b ctl=%h, want 8 0 a5", d, e, oc);
        end
        op(0, 1'b1, 384'd3, 384'd5, 8'h3C, 0, d, e, oc, lat);
        tests++;
        if (d !== 384'd6 || oc !== 8'h3C || lat != ref_steps(3, 13) + 2) begin
            fails++;
            $display("FAIL b2b_div: dat=%0d ctl=%h lat=%0d, want 6 3c %0d", d, oc, lat, ref_steps(3, 13) + 2);
        end
    endtask

    task automatic test_bls();
        logic [383:0] d; logic e; logic [7:0] oc; int lat;
        logic [383:0] a, b;
        op(3, 1'b0, GX, 384'd0, 8'h11, 0, d, e, oc, lat);
        tests++;
        if (e !== 1'b0 || d >= P_BLS || mulmod_big(GX, d) !== 384'd1 || lat > MAX_BLS + 2) begin
            fails++;
            $display("FAIL bls_inv_gx: dat=%h err=%b lat=%0d, want Gx*dat==1 mod P", d, e, lat);
        end
        for (int k = 0; k < 3; k++) begin
            a = rand_bls();
            if (a == '0) a = 384'd1;
            b = rand_bls();
            op(3, 1'b1, a, b, 8'(k), 0, d, e, oc, lat);
            tests++;
            if (e !== 1'b0 || d >= P_BLS || mulmod_big(a, d) !== b || lat > MAX_BLS + 2) begin
                fails++;
                $display("FAIL bls_div%0d: dat=%h err=%b lat=%0d, want a*dat==%h mod P", k, d, e, lat, b);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [383:0] d; logic e; logic [7:0] oc; int lat;
        logic seen;
        mode = 1'b0; a_in = 384'd3; ctl_in = 8'hC3; val[0] = 1'b1;
        @(negedge clk);
        val[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (o_rdy_v[0] !== 1'b1 || o_val_v[0] !== 1'b0 || o_err_v[0] !== 1'b0 ||
            dat_v[0] !== '0 || octl_v[0] !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid: rdy=%b val=%b err=%b dat=%0d ctl=%h, want 1 0 0 0 00",
                     o_rdy_v[0], o_val_v[0], o_err_v[0], dat_v[0], octl_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (o_val_v[0] !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL stale_val: o_val seen=%b after reset, want 0", seen);
        end
        op(0, 1'b0, 384'd3, 384'd0, 8'h77, 0, d, e, oc, lat);
        tests++;
        if (d !== 384'd9 || e !== 1'b0 || oc !== 8'h77) begin
            fails++;
            $display("FAIL post_reset_inv3: dat=%0d err=%b ctl=%h, want 9 0 77", d, e, oc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_field(0, 13, 16, 0);
        test_field(1, 13, 2, 0);
        test_field(2, P_MID, 128, 150);
        test_back_to_back();
        test_bls();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
